// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared raster-timing definitions for the VGA display path.
//   - COORD_W / COORD_MAX : width of every counter and address, and the
//                           longest axis (in ticks) that width can count.
//   - axis_timing_t       : sync / back porch / active / front porch of one
//                           axis, all in pixel ticks (horizontal) or lines.
//   - SVGA_72_* / VGA_60_*: the two supported display modes.
//   - axis_total()        : full period of one axis.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int COORD_W   = 11;
   localparam int COORD_MAX = 1 << COORD_W;

   typedef struct packed {
      int sync;
      int bp;
      int act;
      int fp;
   } axis_timing_t;

   // 800x600 @ 72 Hz, 50 MHz pixel clock
   localparam axis_timing_t SVGA_72_H = '{sync: 120, bp: 64, act: 800, fp: 56};
   localparam axis_timing_t SVGA_72_V = '{sync: 6,   bp: 23, act: 600, fp: 37};

   // 640x480 @ 60 Hz, 25 MHz pixel clock (syncs are active-low in this mode)
   localparam axis_timing_t VGA_60_H  = '{sync: 96,  bp: 48, act: 640, fp: 16};
   localparam axis_timing_t VGA_60_V  = '{sync: 2,   bp: 33, act: 480, fp: 10};

   function automatic int axis_total(input int sync, input int bp,
                                     input int act, input int fp);
      return sync + bp + act + fp;
   endfunction

endpackage : vga_timing_pkg

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   Modulo-N counter for one raster axis, with a registered in-range flag.
//
//   Ports
//     clk, rst_n   : clock, asynchronous active-low reset
//     cnt_en_i     : advance the count by one (wrapping N-1 -> 0)
//     smp_en_i     : refresh the in-range flag from the current count
//     cnt_o        : current count, 0..N-1
//     wrap_o       : high on an enabled step out of N-1 (count returns to 0)
//     in_range_o   : registered (LO <= count < HI), sampled on smp_en_i
//
//   The compare has its own enable because the vertical axis steps once per
//   line but its flag must be re-sampled on every pixel tick, so that it
//   carries the same one-tick latency as every other raster output.
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int N  = 1040,
   parameter int LO = 0,
   parameter int HI = 120
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cnt_en_i,
   input  logic               smp_en_i,
   output logic [COORD_W-1:0] cnt_o,
   output logic               wrap_o,
   output logic               in_range_o
);

   localparam logic [COORD_W-1:0] LAST = COORD_W'(N - 1);

   logic [COORD_W-1:0] cnt_q, cnt_d;
   logic               in_range_q, in_range_d;
   logic               at_last;

   assign at_last = (cnt_q == LAST);

   // NOTE: every variable driven here is given a default first, so no path
   // leaves it unassigned and no latch can be inferred.
   always_comb begin
      cnt_d      = cnt_q;
      in_range_d = in_range_q;
      if (cnt_en_i) begin
         cnt_d = at_last ? '0 : cnt_q + 1'b1;
      end
      if (smp_en_i) begin
         in_range_d = (int'(cnt_q) >= LO) && (int'(cnt_q) < HI);
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         in_range_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         in_range_q <= in_range_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign wrap_o     = cnt_en_i & at_last;
   assign in_range_o = in_range_q;

endmodule : vga_axis_counter

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator: sync pulses, active-area flag and the column /
//   row addresses (c1 / c2) consumed by the downstream pixel controller.
//
//   Ports
//     clk, rst_n      : clock, asynchronous active-low reset
//     pix_en          : pixel tick enable (tie high when pixel clock = clk)
//     hsync_sig       : horizontal sync, polarity set by SYNC_POL
//     vsync_sig       : vertical sync, polarity set by SYNC_POL
//     ready_sig       : current pixel lies in the active area
//     column_addr_sig : active column 0..H_ACT-1, 0 outside the active area
//     row_addr_sig    : active row 0..V_ACT-1, 0 outside the active area
//     frame_start     : one-tick pulse at the raster origin
//
//   Every output is registered from the pre-increment counter values, so
//   outputs trail the counters by exactly one pixel tick. Nothing changes
//   on a clk edge with pix_en low.
// -----------------------------------------------------------------------------
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_SYNC   = SVGA_72_H.sync,
   parameter int H_BP     = SVGA_72_H.bp,
   parameter int H_ACT    = SVGA_72_H.act,
   parameter int H_FP     = SVGA_72_H.fp,
   parameter int V_SYNC   = SVGA_72_V.sync,
   parameter int V_BP     = SVGA_72_V.bp,
   parameter int V_ACT    = SVGA_72_V.act,
   parameter int V_FP     = SVGA_72_V.fp,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_en,
   output logic               hsync_sig,
   output logic               vsync_sig,
   output logic               ready_sig,
   output logic [COORD_W-1:0] column_addr_sig,
   output logic [COORD_W-1:0] row_addr_sig,
   output logic               frame_start
);

   localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACT, H_FP);
   localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACT, V_FP);
   localparam int H_START = H_SYNC + H_BP;
   localparam int H_END   = H_START + H_ACT;
   localparam int V_START = V_SYNC + V_BP;
   localparam int V_END   = V_START + V_ACT;

   localparam logic [COORD_W-1:0] H_START_C = COORD_W'(H_START);
   localparam logic [COORD_W-1:0] V_START_C = COORD_W'(V_START);

   // Both axes must fit the 11-bit counters.
   if (H_TOTAL > COORD_MAX) begin : g_h_total_too_long
      $error("vga_sync_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, COORD_MAX);
   end
   if (V_TOTAL > COORD_MAX) begin : g_v_total_too_long
      $error("vga_sync_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, COORD_MAX);
   end

   // ---------------------------------------------------------------------
   // Axis counters; each owns its sync-window compare.
   // ---------------------------------------------------------------------
   logic [COORD_W-1:0] cnt_h, cnt_v;
   logic               h_wrap, v_wrap;
   logic               h_in_sync, v_in_sync;

   vga_axis_counter #(
      .N  (H_TOTAL),
      .LO (0),
      .HI (H_SYNC)
   ) u_h_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_en_i   (pix_en),
      .smp_en_i   (pix_en),
      .cnt_o      (cnt_h),
      .wrap_o     (h_wrap),
      .in_range_o (h_in_sync)
   );

   // The line counter steps only on the tick that ends a line; h_wrap is
   // already qualified by pix_en.
   vga_axis_counter #(
      .N  (V_TOTAL),
      .LO (0),
      .HI (V_SYNC)
   ) u_v_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_en_i   (h_wrap),
      .smp_en_i   (pix_en),
      .cnt_o      (cnt_v),
      .wrap_o     (v_wrap),
      .in_range_o (v_in_sync)
   );

   // The sync flags reset to 0, which maps to the deasserted level for
   // either polarity.
   assign hsync_sig = SYNC_POL ? h_in_sync : ~h_in_sync;
   assign vsync_sig = SYNC_POL ? v_in_sync : ~v_in_sync;

   // ---------------------------------------------------------------------
   // Active area, addresses and frame marker.
   // ---------------------------------------------------------------------
   logic               active;
   logic               ready_q, ready_d;
   logic [COORD_W-1:0] col_q, col_d;
   logic [COORD_W-1:0] row_q, row_d;
   logic               frame_start_q, frame_start_d;
   // High while the counters sit at (0,0): set by reset and by the tick
   // that wraps both axes, cleared by any other tick. This avoids a 22-bit
   // zero compare on the counters.
   logic               origin_q, origin_d;

   assign active = (int'(cnt_h) >= H_START) && (int'(cnt_h) < H_END) &&
                   (int'(cnt_v) >= V_START) && (int'(cnt_v) < V_END);

   always_comb begin
      ready_d       = ready_q;
      col_d         = col_q;
      row_d         = row_q;
      frame_start_d = frame_start_q;
      origin_d      = origin_q;
      if (pix_en) begin
         ready_d       = active;
         // Addresses are forced to 0 outside the active area, never stale.
         col_d         = active ? cnt_h - H_START_C : '0;
         row_d         = active ? cnt_v - V_START_C : '0;
         frame_start_d = origin_q;
         origin_d      = v_wrap;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q       <= 1'b0;
         col_q         <= '0;
         row_q         <= '0;
         frame_start_q <= 1'b0;
         origin_q      <= 1'b1;
      end else begin
         ready_q       <= ready_d;
         col_q         <= col_d;
         row_q         <= row_d;
         frame_start_q <= frame_start_d;
         origin_q      <= origin_d;
      end
   end

   assign ready_sig       = ready_q;
   assign column_addr_sig = col_q;
   assign row_addr_sig    = row_q;
   assign frame_start     = frame_start_q;

endmodule : vga_sync_gen

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Three instances share one clock:
//     u_dut_a : 800x600@72 defaults, active-high syncs
//     u_dut_c : 640x480@60, active-low syncs
//     u_dut_b : tiny raster (13 x 9 ticks) for whole-frame, enable-gating,
//               wrap-coincidence and mid-frame reset checks
//   Outputs are sampled on the falling edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Instances
   // ---------------------------------------------------------------------
   logic        rst_n_ac, pix_en_ac, rst_n_b, pix_en_b;
   logic        hs_a, vs_a, rdy_a, fs_a, hs_c, vs_c, rdy_c, fs_c;
   logic        hs_b, vs_b, rdy_b, fs_b;
   logic [10:0] col_a, row_a, col_c, row_c, col_b, row_b;

   vga_sync_gen u_dut_a (
      .clk(clk), .rst_n(rst_n_ac), .pix_en(pix_en_ac),
      .hsync_sig(hs_a), .vsync_sig(vs_a), .ready_sig(rdy_a),
      .column_addr_sig(col_a), .row_addr_sig(row_a), .frame_start(fs_a)
   );

   vga_sync_gen #(
      .H_SYNC(96), .H_BP(48), .H_ACT(640), .H_FP(16),
      .V_SYNC(2),  .V_BP(33), .V_ACT(480), .V_FP(10), .SYNC_POL(1'b0)
   ) u_dut_c (
      .clk(clk), .rst_n(rst_n_ac), .pix_en(pix_en_ac),
      .hsync_sig(hs_c), .vsync_sig(vs_c), .ready_sig(rdy_c),
      .column_addr_sig(col_c), .row_addr_sig(row_c), .frame_start(fs_c)
   );

   vga_sync_gen #(
      .H_SYNC(3), .H_BP(2), .H_ACT(6), .H_FP(2),
      .V_SYNC(2), .V_BP(1), .V_ACT(4), .V_FP(2), .SYNC_POL(1'b1)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .pix_en(pix_en_b),
      .hsync_sig(hs_b), .vsync_sig(vs_b), .ready_sig(rdy_b),
      .column_addr_sig(col_b), .row_addr_sig(row_b), .frame_start(fs_b)
   );

   // ---------------------------------------------------------------------
   // Small raster model: 13 ticks/line (sync 3, bp 2, act 6, fp 2),
   // 9 lines/frame (sync 2, bp 1, act 4, fp 2). k = pix ticks since reset.
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic        fs;
      logic        hs;
      logic        vs;
      logic        rdy;
      logic [10:0] col;
      logic [10:0] row;
   } obs_t;

   obs_t obs_b;
   assign obs_b = {fs_b, hs_b, vs_b, rdy_b, col_b, row_b};

   function automatic obs_t exp_b(input int k);
      obs_t e;
      int   n;
      int   h;
      int   v;
      e = '0;
      if (k == 0) return e;
      n     = k - 1;
      h     = n % 13;
      v     = (n / 13) % 9;
      e.fs  = (h == 0) && (v == 0);
      e.hs  = (h < 3);
      e.vs  = (v < 2);
      e.rdy = (h >= 5) && (h < 11) && (v >= 3) && (v < 7);
      if (e.rdy) begin
         e.col = 11'(h - 5);
         e.row = 11'(v - 3);
      end
      return e;
   endfunction

   int b_k, b_bad, b_first_bad, b_clk;
   int b_vs_cnt, b_rdy_cnt, b_row_max;
   int fs_ticks[$];
   int fs_rise_clk[$];
   logic b_prev_fs;

   task automatic b_clear();
      b_bad = 0; b_first_bad = -1; b_clk = 0;
      b_vs_cnt = 0; b_rdy_cnt = 0; b_row_max = 0;
      b_prev_fs = 1'b0;
      fs_ticks.delete();
      fs_rise_clk.delete();
   endtask

   // One clk with the given enable; compares DUT B against the model.
   task automatic step_b(input logic en);
      logic ticked;
      pix_en_b = en;
      @(posedge clk);
      ticked = en && rst_n_b;
      if (ticked) b_k++;
      b_clk++;
      @(negedge clk);
      if (obs_b !== exp_b(b_k)) begin
         if (b_bad == 0) b_first_bad = b_k;
         b_bad++;
      end
      if (ticked && b_k <= 234) begin
         if (vs_b)  b_vs_cnt++;
         if (rdy_b) b_rdy_cnt++;
         if (int'(row_b) > b_row_max) b_row_max = int'(row_b);
      end
      if (ticked && fs_b) fs_ticks.push_back(b_k);
      if (fs_b && !b_prev_fs) fs_rise_clk.push_back(b_clk);
      b_prev_fs = fs_b;
   endtask

   task automatic reset_b();
      rst_n_b  = 1'b0;
      pix_en_b = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n_b = 1'b1;
      b_k     = 0;
      b_clear();
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   int a_hs, a_vs, a_rdy, a_first, a_first_col, a_first_row, a_max_col;
   int a_last_row, a_fs, a_idle_bad, a_fall_rdy, a_fall_col;
   int c_hs_low, c_vs_low, c_rdy, c_first, c_first_row, c_max_col;

   initial begin
      rst_n_ac = 1'b0; pix_en_ac = 1'b1;
      rst_n_b  = 1'b0; pix_en_b  = 1'b0;
      b_k = 0;
      b_clear();

      // ---- Reset state, A and C ----
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("a_rst_hsync", hs_a, 0);
      check("a_rst_vsync", vs_a, 0);
      check("a_rst_ready", rdy_a, 0);
      check("a_rst_col",   col_a, 0);
      check("a_rst_row",   row_a, 0);
      check("a_rst_fs",    fs_a, 0);
      check("c_rst_hsync_idle_high", hs_c, 1);
      check("c_rst_vsync_idle_high", vs_c, 1);

      // ---- Line / frame-top timing on A (32 lines) and C (36 lines) ----
      rst_n_ac = 1'b1;
      a_hs = 0; a_vs = 0; a_rdy = 0; a_first = 0; a_first_col = -1;
      a_first_row = -1; a_max_col = 0; a_last_row = -1; a_fs = 0;
      a_idle_bad = 0; a_fall_rdy = -1; a_fall_col = -1;
      c_hs_low = 0; c_vs_low = 0; c_rdy = 0; c_first = 0;
      c_first_row = -1; c_max_col = 0;
      for (int k = 1; k <= 32 * 1040; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) begin
            check("a_first_tick_fs",    fs_a, 1);
            check("a_first_tick_hsync", hs_a, 1);
            check("a_first_tick_vsync", vs_a, 1);
            check("c_first_tick_fs",    fs_c, 1);
            check("c_first_tick_hsync", hs_c, 0);
         end
         if (k <= 3 * 1040 && hs_a) a_hs++;
         if (vs_a) a_vs++;
         if (fs_a) a_fs++;
         if (!rdy_a && (col_a != 0 || row_a != 0)) a_idle_bad++;
         if (rdy_a) begin
            a_rdy++;
            if (a_first == 0) begin
               a_first = k; a_first_col = int'(col_a); a_first_row = int'(row_a);
            end
            if (int'(col_a) > a_max_col) a_max_col = int'(col_a);
            a_last_row = int'(row_a);
         end
         if (k == 29 * 1040 + 185 + 800) begin
            a_fall_rdy = int'(rdy_a); a_fall_col = int'(col_a);
         end
         if (k <= 36 * 800) begin
            if (k <= 800 && !hs_c) c_hs_low++;
            if (!vs_c) c_vs_low++;
            if (rdy_c) begin
               c_rdy++;
               if (c_first == 0) begin
                  c_first = k; c_first_row = int'(row_c);
               end
               if (int'(col_c) > c_max_col) c_max_col = int'(col_c);
            end
         end
      end
      check("a_hsync_ticks_3_lines", a_hs, 360);
      check("a_vsync_ticks",         a_vs, 6 * 1040);
      check("a_frame_start_count",   a_fs, 1);
      check("a_ready_first_tick",    a_first, 29 * 1040 + 185);
      check("a_ready_first_col",     a_first_col, 0);
      check("a_ready_first_row",     a_first_row, 0);
      check("a_col_max",             a_max_col, 799);
      check("a_ready_ticks",         a_rdy, 3 * 800);
      check("a_last_row",            a_last_row, 2);
      check("a_ready_fall",          a_fall_rdy, 0);
      check("a_col_after_fall",      a_fall_col, 0);
      check("a_idle_addr_nonzero",   a_idle_bad, 0);
      check("c_hsync_low_ticks",     c_hs_low, 96);
      check("c_vsync_low_ticks",     c_vs_low, 2 * 800);
      check("c_ready_first_tick",    c_first, 35 * 800 + 145);
      check("c_ready_first_row",     c_first_row, 0);
      check("c_col_max",             c_max_col, 639);
      check("c_ready_ticks",         c_rdy, 640);

      // ---- B: two full frames with pix_en held high ----
      reset_b();
      check("b_rst_state", obs_b, 0);
      repeat (235) step_b(1'b1);
      check("b_run_trace_bad", b_bad, 0);
      if (b_bad != 0) $display("first divergence at tick %0d", b_first_bad);
      check("b_fs_count",        fs_ticks.size(), 3);
      check("b_fs_tick0",        (fs_ticks.size() > 0) ? fs_ticks[0] : -1, 1);
      check("b_wrap_fs_tick",    (fs_ticks.size() > 1) ? fs_ticks[1] : -1, 118);
      check("b_vsync_ticks",     b_vs_cnt, 2 * 26);
      check("b_ready_ticks",     b_rdy_cnt, 2 * 24);
      check("b_row_max",         b_row_max, 3);

      // ---- B: pix_en toggling every clk ----
      reset_b();
      for (int i = 0; i < 480; i++) step_b((i % 2) == 0);
      check("b_gated_trace_bad", b_bad, 0);
      check("b_gated_fs_rises",  fs_rise_clk.size(), 3);
      check("b_gated_period",
            (fs_rise_clk.size() > 1) ? fs_rise_clk[1] - fs_rise_clk[0] : -1,
            234);

      // ---- B: reset in the middle of the active area ----
      reset_b();
      repeat (73) step_b(1'b1);
      check("b_mid_ready", rdy_b, 1);
      check("b_mid_col",   col_b, 2);
      check("b_mid_row",   row_b, 2);
      #2;
      rst_n_b = 1'b0;
      #1;
      check("b_async_rst_state", obs_b, 0);
      @(negedge clk);
      rst_n_b = 1'b1;
      b_k = 0;
      b_clear();
      step_b(1'b1);
      check("b_restart_fs",    fs_b, 1);
      check("b_restart_hsync", hs_b, 1);
      check("b_restart_vsync", vs_b, 1);
      repeat (117) step_b(1'b1);
      check("b_restart_trace_bad", b_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_vga_sync_gen
